// File: rtl/multicycle_control_pkg.sv
// cpu_defs: shared definitions for the multicycle CPU control path.
//   - opcode constants (instruction bits [31:26])
//   - state_t: 12 control states in a 4-bit encoding
//   - ALUSrcB and PCSrc select encodings
//   - isKnownOp(): true for every opcode the control unit sequences
package cpu_defs;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        EXEC_R   = 4'd2,
        WB_R     = 4'd3,
        EXEC_I   = 4'd4,
        WB_I     = 4'd5,
        MEM_ADDR = 4'd6,
        MEM_RD   = 4'd7,
        WB_MEM   = 4'd8,
        MEM_WR   = 4'd9,
        BRANCH   = 4'd10,
        JUMP     = 4'd11
    } state_t;

    localparam logic [1:0] ALUB_RT   = 2'b00;
    localparam logic [1:0] ALUB_FOUR = 2'b01;
    localparam logic [1:0] ALUB_IMM  = 2'b10;

    localparam logic [1:0] PC_SEQ = 2'b00;
    localparam logic [1:0] PC_BR  = 2'b01;
    localparam logic [1:0] PC_JMP = 2'b10;

    function automatic logic isKnownOp(input logic [5:0] op);
        case (op)
            OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J: isKnownOp = 1'b1;
            default:                                       isKnownOp = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control_out_decode.sv
// mc_out_decode: Moore output decoder for the multicycle control unit.
// Pure function of the current state plus the stall and reset masks.
// Ports:
//   state      in   current control state
//   stall      in   forces every write enable / pulse low, selects unchanged
//   rst        in   forces every output low
//   SelectIns, RegWrite, RegDst, ALUSrcA, ALUSrcB, MemWrite, MemtoReg,
//   BEQ, PCSrc, PCWrite, IRWrite, instr_done   out   datapath controls
module mc_out_decode
    import cpu_defs::*;
(
    input  state_t     state,
    input  logic       stall,
    input  logic       rst,
    output logic       SelectIns,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       MemWrite,
    output logic       MemtoReg,
    output logic       BEQ,
    output logic [1:0] PCSrc,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       instr_done
);

    always_comb begin
        SelectIns  = 1'b0;
        RegWrite   = 1'b0;
        RegDst     = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = ALUB_RT;
        MemWrite   = 1'b0;
        MemtoReg   = 1'b0;
        BEQ        = 1'b0;
        PCSrc      = PC_SEQ;
        PCWrite    = 1'b0;
        IRWrite    = 1'b0;
        instr_done = 1'b0;

        case (state)
            FETCH: begin
                IRWrite = 1'b1;
                PCWrite = 1'b1;
                ALUSrcB = ALUB_FOUR;
            end
            EXEC_R: begin
                ALUSrcA = 1'b1;
                ALUSrcB = ALUB_RT;
            end
            WB_R: begin
                RegWrite   = 1'b1;
                RegDst     = 1'b1;
                ALUSrcA    = 1'b1;
                ALUSrcB    = ALUB_RT;
                instr_done = 1'b1;
            end
            EXEC_I, MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = ALUB_IMM;
            end
            WB_I: begin
                RegWrite   = 1'b1;
                ALUSrcA    = 1'b1;
                ALUSrcB    = ALUB_IMM;
                instr_done = 1'b1;
            end
            MEM_RD: begin
                SelectIns = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = ALUB_IMM;
            end
            WB_MEM: begin
                RegWrite   = 1'b1;
                MemtoReg   = 1'b1;
                instr_done = 1'b1;
            end
            MEM_WR: begin
                MemWrite   = 1'b1;
                SelectIns  = 1'b1;
                ALUSrcA    = 1'b1;
                ALUSrcB    = ALUB_IMM;
                instr_done = 1'b1;
            end
            BRANCH: begin
                BEQ        = 1'b1;
                PCSrc      = PC_BR;
                ALUSrcA    = 1'b1;
                ALUSrcB    = ALUB_RT;
                instr_done = 1'b1;
            end
            JUMP: begin
                PCWrite    = 1'b1;
                PCSrc      = PC_JMP;
                instr_done = 1'b1;
            end
            default: ;
        endcase

        // Stall drops every state-changing strobe but leaves mux selects alone
        // so the datapath keeps presenting the same operands.
        if (stall) begin
            RegWrite   = 1'b0;
            MemWrite   = 1'b0;
            PCWrite    = 1'b0;
            IRWrite    = 1'b0;
            BEQ        = 1'b0;
            instr_done = 1'b0;
        end

        if (rst) begin
            SelectIns  = 1'b0;
            RegWrite   = 1'b0;
            RegDst     = 1'b0;
            ALUSrcA    = 1'b0;
            ALUSrcB    = '0;
            MemWrite   = 1'b0;
            MemtoReg   = 1'b0;
            BEQ        = 1'b0;
            PCSrc      = '0;
            PCWrite    = 1'b0;
            IRWrite    = 1'b0;
            instr_done = 1'b0;
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: Moore control unit of the multicycle CPU.
// Sequences FETCH -> DECODE -> execute/memory/write-back states and drives
// the Datapath control inputs.
// Parameters:
//   OPW         opcode width (6)
// Ports:
//   clk         in   rising-edge clock
//   rst         in   synchronous active-high reset; forces all outputs low
//   opcode      in   IR[31:26]; only sampled in DECODE
//   stall       in   hold state and op register, suppress write enables
//   SelectIns .. IRWrite   out   datapath controls (see mc_out_decode)
//   instr_done  out  pulse in the final state of each instruction
//   illegal_op  out  pulse in DECODE for an unrecognised opcode
module multicycle_control
    import cpu_defs::*;
#(
    parameter int OPW = 6
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [OPW-1:0] opcode,
    input  logic           stall,
    output logic           SelectIns,
    output logic           RegWrite,
    output logic           RegDst,
    output logic           ALUSrcA,
    output logic [1:0]     ALUSrcB,
    output logic           MemWrite,
    output logic           MemtoReg,
    output logic           BEQ,
    output logic [1:0]     PCSrc,
    output logic           PCWrite,
    output logic           IRWrite,
    output logic           instr_done,
    output logic           illegal_op
);

    localparam logic [OPW-1:0] opRtype = OPW'(OP_RTYPE);
    localparam logic [OPW-1:0] opAddi  = OPW'(OP_ADDI);
    localparam logic [OPW-1:0] opLw    = OPW'(OP_LW);
    localparam logic [OPW-1:0] opSw    = OPW'(OP_SW);
    localparam logic [OPW-1:0] opBeq   = OPW'(OP_BEQ);
    localparam logic [OPW-1:0] opJ     = OPW'(OP_J);

    state_t         state;
    logic [OPW-1:0] op;
    logic           knownOp;

    always_comb begin
        knownOp = 1'b0;
        case (opcode)
            opRtype, opAddi, opLw, opSw, opBeq, opJ: knownOp = 1'b1;
            default:                                 knownOp = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH;
            op    <= '0;
        end else if (!stall) begin
            case (state)
                FETCH: state <= DECODE;
                DECODE: begin
                    op <= opcode;
                    case (opcode)
                        opRtype:     state <= EXEC_R;
                        opAddi:      state <= EXEC_I;
                        opLw, opSw:  state <= MEM_ADDR;
                        opBeq:       state <= BRANCH;
                        opJ:         state <= JUMP;
                        default:     state <= FETCH;
                    endcase
                end
                EXEC_R:   state <= WB_R;
                EXEC_I:   state <= WB_I;
                // Load vs store is taken from the latched op, not the live
                // opcode, so IR changes after DECODE cannot redirect it.
                MEM_ADDR: state <= (op == opLw) ? MEM_RD : MEM_WR;
                MEM_RD:   state <= WB_MEM;
                default:  state <= FETCH;
            endcase
        end
    end

    // Only output with an opcode path; still masked by stall and reset.
    assign illegal_op = !rst && !stall && (state == DECODE) && !knownOp;

    mc_out_decode u_outDecode (
        .state      (state),
        .stall      (stall),
        .rst        (rst),
        .SelectIns  (SelectIns),
        .RegWrite   (RegWrite),
        .RegDst     (RegDst),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .MemWrite   (MemWrite),
        .MemtoReg   (MemtoReg),
        .BEQ        (BEQ),
        .PCSrc      (PCSrc),
        .PCWrite    (PCWrite),
        .IRWrite    (IRWrite),
        .instr_done (instr_done)
    );

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed test-plan steps
// followed by randomized opcode/stall/reset traffic, compared every cycle
// against a cycle-position reference model of the instruction sequences.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       stall = 1'b0;
    logic [5:0] opcode = 6'b000000;

    logic       SelectIns, RegWrite, RegDst, ALUSrcA, MemWrite, MemtoReg;
    logic       BEQ, PCWrite, IRWrite, instr_done, illegal_op;
    logic [1:0] ALUSrcB, PCSrc;

    int passed = 0;
    int total  = 0;

    // Reference model: position within the current instruction (0 = fetch
    // cycle, 1 = decode cycle, ...) and the opcode captured at decode.
    int         k   = 0;
    logic [5:0] mOp = 6'b000000;

    always #5 clk = ~clk;

    multicycle_control #(.OPW(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .stall      (stall),
        .SelectIns  (SelectIns),
        .RegWrite   (RegWrite),
        .RegDst     (RegDst),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .MemWrite   (MemWrite),
        .MemtoReg   (MemtoReg),
        .BEQ        (BEQ),
        .PCSrc      (PCSrc),
        .PCWrite    (PCWrite),
        .IRWrite    (IRWrite),
        .instr_done (instr_done),
        .illegal_op (illegal_op)
    );

    // Vector layout: sel rw rd asa asb[2] mw m2r beq pcs[2] pcw irw done ill
    function automatic logic [14:0] mk(
        input logic sel, input logic rw, input logic rd, input logic asa,
        input logic [1:0] asb, input logic mw, input logic m2r, input logic beq,
        input logic [1:0] pcs, input logic pcw, input logic irw,
        input logic done, input logic ill);
        return {sel, rw, rd, asa, asb, mw, m2r, beq, pcs, pcw, irw, done, ill};
    endfunction

    function automatic int lenOf(input logic [5:0] o);
        case (o)
            6'b000000: return 4;
            6'b001000: return 4;
            6'b100011: return 5;
            6'b101011: return 4;
            6'b000100: return 3;
            6'b000010: return 3;
            default:   return 2;
        endcase
    endfunction

    function automatic logic [14:0] expVec(input int kk, input logic [5:0] o,
                                           input logic [5:0] now);
        if (kk == 0) return mk(0,0,0,0,2'b01,0,0,0,2'b00,1,1,0,0);
        if (kk == 1) return mk(0,0,0,0,2'b00,0,0,0,2'b00,0,0,0,(lenOf(now) == 2));
        case (o)
            6'b000000: return (kk == 2) ? mk(0,0,0,1,2'b00,0,0,0,2'b00,0,0,0,0)
                                        : mk(0,1,1,1,2'b00,0,0,0,2'b00,0,0,1,0);
            6'b001000: return (kk == 2) ? mk(0,0,0,1,2'b10,0,0,0,2'b00,0,0,0,0)
                                        : mk(0,1,0,1,2'b10,0,0,0,2'b00,0,0,1,0);
            6'b100011: return (kk == 2) ? mk(0,0,0,1,2'b10,0,0,0,2'b00,0,0,0,0)
                            : (kk == 3) ? mk(1,0,0,1,2'b10,0,0,0,2'b00,0,0,0,0)
                                        : mk(0,1,0,0,2'b00,0,1,0,2'b00,0,0,1,0);
            6'b101011: return (kk == 2) ? mk(0,0,0,1,2'b10,0,0,0,2'b00,0,0,0,0)
                                        : mk(1,0,0,1,2'b10,1,0,0,2'b00,0,0,1,0);
            6'b000100: return mk(0,0,0,1,2'b00,0,0,1,2'b01,0,0,1,0);
            6'b000010: return mk(0,0,0,0,2'b00,0,0,0,2'b10,1,0,1,0);
            default:   return '0;
        endcase
    endfunction

    // Stall keeps selects, clears rw/mw/beq/pcw/irw/done/ill.
    function automatic logic [14:0] stallMask();
        return mk(1,0,1,1,2'b11,0,1,0,2'b11,0,0,0,0);
    endfunction

    task automatic step(input logic [5:0] opc, input logic st, input logic r,
                        input string tag);
        logic [14:0] expected;
        logic [14:0] observed;
        @(posedge clk);
        #1;
        opcode = opc;
        stall  = st;
        rst    = r;
        if (r)       expected = '0;
        else if (st) expected = expVec(k, mOp, opc) & stallMask();
        else         expected = expVec(k, mOp, opc);
        @(negedge clk);
        observed = {SelectIns, RegWrite, RegDst, ALUSrcA, ALUSrcB, MemWrite,
                    MemtoReg, BEQ, PCSrc, PCWrite, IRWrite, instr_done, illegal_op};
        total = total + 1;
        assert (observed === expected) passed = passed + 1;
        else $error("FAIL %s pos=%0d op=%b observed=%b expected=%b",
                    tag, k, opc, observed, expected);
        if (r) begin
            k   = 0;
            mOp = 6'b000000;
        end else if (!st) begin
            if (k == 1) mOp = opc;
            k = k + 1;
            if (k >= ((k == 2) ? lenOf(mOp) : lenOf(mOp))) k = 0;
        end
    endtask

    task automatic runInstr(input logic [5:0] opc, input string tag);
        int n;
        n = lenOf(opc);
        for (int i = 0; i < n; i++) step(opc, 1'b0, 1'b0, tag);
    endtask

    initial begin
        // reset
        step(6'b000000, 1'b0, 1'b1, "reset");
        step(6'b000000, 1'b0, 1'b1, "reset");
        // 1: R-type, then next fetch
        runInstr(6'b000000, "rtype");
        // 2: LW
        runInstr(6'b100011, "lw");
        // 3: SW
        runInstr(6'b101011, "sw");
        // 4: BEQ then J
        runInstr(6'b000100, "beq");
        runInstr(6'b000010, "jump");
        // 5: illegal then ADDI
        runInstr(6'b111111, "illegal");
        runInstr(6'b001000, "addi");
        // opcode change after decode is ignored
        step(6'b000000, 1'b0, 1'b0, "opchg");
        step(6'b000000, 1'b0, 1'b0, "opchg");
        step(6'b100011, 1'b0, 1'b0, "opchg");
        step(6'b111111, 1'b0, 1'b0, "opchg");
        // 6a: LW with 3-cycle stall in MEM_RD
        step(6'b100011, 1'b0, 1'b0, "lwstall");
        step(6'b100011, 1'b0, 1'b0, "lwstall");
        step(6'b100011, 1'b0, 1'b0, "lwstall");
        for (int i = 0; i < 3; i++) step(6'b100011, 1'b1, 1'b0, "lwstall");
        step(6'b100011, 1'b0, 1'b0, "lwstall");
        step(6'b100011, 1'b0, 1'b0, "lwstall");
        // stall during decode on an illegal opcode, then rst+stall together
        step(6'b000000, 1'b0, 1'b0, "decstall");
        step(6'b111111, 1'b1, 1'b0, "decstall");
        step(6'b111111, 1'b0, 1'b0, "decstall");
        step(6'b000000, 1'b1, 1'b1, "rststall");
        // 6b: reset in MEM_ADDR aborts LW
        step(6'b100011, 1'b0, 1'b0, "lwrst");
        step(6'b100011, 1'b0, 1'b0, "lwrst");
        step(6'b100011, 1'b0, 1'b1, "lwrst");
        runInstr(6'b100011, "lwrst");

        // randomized traffic
        for (int c = 0; c < 600; c++) begin
            logic [5:0] o;
            logic       s;
            logic       r;
            case ($urandom_range(0, 7))
                0: o = 6'b000000;
                1: o = 6'b001000;
                2: o = 6'b100011;
                3: o = 6'b101011;
                4: o = 6'b000100;
                5: o = 6'b000010;
                default: o = 6'($urandom);
            endcase
            s = ($urandom_range(0, 9) == 0);
            r = ($urandom_range(0, 49) == 0);
            step(o, s, r, "random");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $display("%0d/%0d checks passed", passed, total + 1);
        $fatal(1, "timeout");
    end

endmodule
